// File: rtl/nios2_onchip_mem_pkg.sv
// Shared constants for the dual-port on-chip RAM: port indices and read latency.
package nios2_onchip_mem_pkg;

    localparam int PORT_S1 = 0;
    localparam int PORT_S2 = 1;

    // Read latency in cycles from the grant edge to readdatavalid.
    function automatic int LAT(input int out_reg);
        return 1 + out_reg;
    endfunction

endpackage

// File: rtl/onchip_mem_rr_arbiter.sv
// Two-requester round-robin arbiter. On a tie, the port that was not granted last time wins.
// clken low suppresses all grants and freezes last_grant.
module onchip_mem_rr_arbiter
    import nios2_onchip_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       last_grant
);

    // Grant decode: a single requester wins outright, and a tie goes to the port not served last.
    always_comb begin
        grant = 2'b00;
        if (clken) begin
            if (req[PORT_S1] && req[PORT_S2]) begin
                if (last_grant == 1'(PORT_S2)) begin
                    grant[PORT_S1] = 1'b1;
                end else begin
                    grant[PORT_S2] = 1'b1;
                end
            end else begin
                grant = req;
            end
        end
    end

    // last_grant remembers the port served most recently. Reset favours s1 on the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'(PORT_S2);
        end else if (grant != 2'b00) begin
            last_grant <= grant[PORT_S2];
        end
    end

endmodule

// File: rtl/nios2_onchip_mem_arb.sv
// Single-port on-chip RAM shared by two Avalon-MM slaves (s1 instruction, s2 data).
// One access per cycle is granted round-robin. Reads return through a valid/port-tag
// pipeline of depth LAT(OUT_REG).
module nios2_onchip_mem_arb
    import nios2_onchip_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 14,
    parameter int    DEPTH     = 11053,
    parameter int    OUT_REG   = 0,
    parameter string INIT_FILE = "first_nios2_system_onchip_mem.hex"
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest
);

    localparam int              LP_LAT   = LAT(OUT_REG);
    localparam int              LP_BE_W  = DATA_W / 8;
    localparam int              LP_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_unused_last_grant;
    logic                w_sel_s2;
    logic [ADDR_W-1:0]   w_addr;
    logic [LP_BE_W-1:0]  w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_write;
    logic                w_read;
    logic                w_do_write;
    logic                w_do_read;
    logic                w_in_range;
    logic [LP_IDX_W-1:0] w_idx;
    logic                w_out_vld;
    logic                w_out_tag;

    // The init image is loaded by the FPGA RAM initialisation flow, not by logic in this module.
    logic w_unused_init;
    assign w_unused_init = (INIT_FILE != "");

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LP_LAT-1:0] r_vld;
    logic [LP_LAT-1:0] r_tag;
    logic [DATA_W-1:0] r_dat [LP_LAT];

    assign w_req[PORT_S1] = s1_chipselect & (s1_read | s1_write);
    assign w_req[PORT_S2] = s2_chipselect & (s2_read | s2_write);

    onchip_mem_rr_arbiter u_arb (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .req        (w_req),
        .grant      (w_grant),
        .last_grant (w_unused_last_grant)
    );

    // With clken low there is no grant, so waitrequest simply mirrors the request.
    assign s1_waitrequest = w_req[PORT_S1] & ~w_grant[PORT_S1];
    assign s2_waitrequest = w_req[PORT_S2] & ~w_grant[PORT_S2];

    assign w_sel_s2 = w_grant[PORT_S2];
    assign w_addr   = w_sel_s2 ? s2_address    : s1_address;
    assign w_be     = w_sel_s2 ? s2_byteenable : s1_byteenable;
    assign w_wdata  = w_sel_s2 ? s2_writedata  : s1_writedata;
    assign w_write  = w_sel_s2 ? s2_write      : s1_write;
    assign w_read   = w_sel_s2 ? s2_read       : s1_read;

    // A write takes priority over a simultaneous read on the same port.
    assign w_do_write = (|w_grant) & w_write;
    assign w_do_read  = (|w_grant) & w_read & ~w_write;
    assign w_in_range = ({1'b0, w_addr} < LP_DEPTH);
    assign w_idx      = w_addr[LP_IDX_W-1:0];

    // Byte-lane write. Out-of-range addresses are dropped, and reset never touches the array.
    always_ff @(posedge clk) begin
        if (w_do_write && w_in_range) begin
            for (int b = 0; b < LP_BE_W; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the RAM word, and later stages shift valid, tag and data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            r_tag <= '0;
            for (int i = 0; i < LP_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else if (clken) begin
            r_vld[0] <= w_do_read;
            r_tag[0] <= w_sel_s2;
            if (w_do_read) begin
                r_dat[0] <= w_in_range ? r_mem[w_idx] : '0;
            end
            for (int i = 1; i < LP_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // A pending valid is held while the block is frozen and appears once clken returns.
    assign w_out_vld = r_vld[LP_LAT-1] & clken;
    assign w_out_tag = r_tag[LP_LAT-1];

    assign s1_readdatavalid = w_out_vld & (w_out_tag == 1'(PORT_S1));
    assign s2_readdatavalid = w_out_vld & (w_out_tag == 1'(PORT_S2));
    assign s1_readdata      = r_dat[LP_LAT-1];
    assign s2_readdata      = r_dat[LP_LAT-1];

endmodule

// File: tb/tb_nios2_onchip_mem_arb.sv
// Scoreboard bench for nios2_onchip_mem_arb. The driver models arbitration and memory
// contents from the behavioural rules and queues the expected read responses. A separate
// monitor compares every cycle's readdatavalid and readdata against those queues.
module tb_nios2_onchip_mem_arb;

    localparam int DW      = 32;
    localparam int AW      = 14;
    localparam int DEPTH   = 11053;
    localparam int OUT_REG = 1;
    localparam int LAT     = 1 + OUT_REG;

    logic          clk = 1'b0;
    logic          reset;
    logic          clken;
    logic [AW-1:0] s1_address, s2_address;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic          s1_chipselect, s2_chipselect;
    logic          s1_read, s2_read, s1_write, s2_write;
    logic [DW-1:0] s1_writedata, s2_writedata;
    logic [DW-1:0] s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid;
    logic          s1_waitrequest, s2_waitrequest;

    always #5 clk = ~clk;

    nios2_onchip_mem_arb #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .OUT_REG   (OUT_REG),
        .INIT_FILE ("first_nios2_system_onchip_mem.hex")
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clken            (clken),
        .s1_address       (s1_address),
        .s1_byteenable    (s1_byteenable),
        .s1_chipselect    (s1_chipselect),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_writedata     (s1_writedata),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s1_waitrequest   (s1_waitrequest),
        .s2_address       (s2_address),
        .s2_byteenable    (s2_byteenable),
        .s2_chipselect    (s2_chipselect),
        .s2_read          (s2_read),
        .s2_write         (s2_write),
        .s2_writedata     (s2_writedata),
        .s2_readdata      (s2_readdata),
        .s2_readdatavalid (s2_readdatavalid),
        .s2_waitrequest   (s2_waitrequest)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          ecyc   = 0;
    int          last_g = 2;
    logic        mon_en = 1'b0;
    logic [31:0] mm [int];
    exp_t        q1 [$];
    exp_t        q2 [$];

    int alist [8] = '{16, 17, 32, 256, 8191, 11052, 0, 7};
    int olist [3] = '{12288, 11053, 16383};

    // Enabled-cycle counter: read latency is measured in cycles where clken was high.
    always @(posedge clk) if (clken) ecyc <= ecyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic set1(input logic c, input logic r, input logic w, input int a,
                        input logic [3:0] be, input logic [31:0] d);
        s1_chipselect = c; s1_read = r; s1_write = w; s1_address = AW'(a);
        s1_byteenable = be; s1_writedata = d;
    endtask

    task automatic set2(input logic c, input logic r, input logic w, input int a,
                        input logic [3:0] be, input logic [31:0] d);
        s2_chipselect = c; s2_read = r; s2_write = w; s2_address = AW'(a);
        s2_byteenable = be; s2_writedata = d;
    endtask

    task automatic idle();
        set1(0, 0, 0, 0, 4'h0, 32'h0);
        set2(0, 0, 0, 0, 4'h0, 32'h0);
    endtask

    // One bus cycle: model the arbitration decision, check waitrequest, and apply the grant to the model.
    task automatic tick();
        bit          r1, r2, wr, rd;
        int          g, a;
        logic [3:0]  be;
        logic [31:0] wd, old;
        exp_t        e;
        @(negedge clk);
        r1 = s1_chipselect && (s1_read || s1_write);
        r2 = s2_chipselect && (s2_read || s2_write);
        g = 0;
        if (clken) begin
            if (r1 && r2)  g = (last_g == 2) ? 1 : 2;
            else if (r1)   g = 1;
            else if (r2)   g = 2;
        end
        chk("wait_s1", 32'(s1_waitrequest), 32'(r1 && g != 1));
        chk("wait_s2", 32'(s2_waitrequest), 32'(r2 && g != 2));
        if (g != 0) begin
            last_g = g;
            if (g == 1) begin
                a = int'(s1_address); be = s1_byteenable; wd = s1_writedata;
                wr = s1_write; rd = s1_read;
            end else begin
                a = int'(s2_address); be = s2_byteenable; wd = s2_writedata;
                wr = s2_write; rd = s2_read;
            end
            if (wr) begin
                if (a < DEPTH) begin
                    old = mm.exists(a) ? mm[a] : 32'h0;
                    mm[a] = merge(old, wd, be);
                end
            end else if (rd) begin
                e.d   = (a < DEPTH && mm.exists(a)) ? mm[a] : 32'h0;
                e.due = ecyc + LAT;
                if (g == 1) q1.push_back(e);
                else        q2.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        q1.delete();
        q2.delete();
        last_g = 2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rdata_after_rst", s1_readdata, 32'h0);
    endtask

    // Monitor: whenever the DUT presents (or should present) a read response, pop and compare.
    always @(negedge clk) begin : mon
        bit e1, e2;
        if (mon_en) begin
            e1 = clken && q1.size() > 0 && q1[0].due == ecyc;
            e2 = clken && q2.size() > 0 && q2[0].due == ecyc;
            chk("rdv_s1", 32'(s1_readdatavalid), 32'(e1));
            chk("rdv_s2", 32'(s2_readdatavalid), 32'(e2));
            if (s1_readdatavalid && e1) begin
                chk("rdata_s1", s1_readdata, q1[0].d);
                void'(q1.pop_front());
            end
            if (s2_readdatavalid && e2) begin
                chk("rdata_s2", s2_readdata, q2[0].d);
                void'(q2.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        reset = 1'b1;
        clken = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset and idle state
        tick();
        chk("rdata_rst_s1", s1_readdata, 32'h0);
        chk("rdata_rst_s2", s2_readdata, 32'h0);
        tick();

        // Give every address used below a known value
        foreach (alist[i]) begin
            set1(1, 0, 1, alist[i], 4'hF, $urandom);
            tick();
        end

        // Partial byte-lane write, then read back on the very next cycle
        set1(1, 0, 1, 16, 4'hF, 32'h0);        tick();
        set1(1, 0, 1, 16, 4'h5, 32'hDEADBEEF); tick();
        set1(1, 1, 0, 16, 4'h0, 32'h0);        tick();
        idle();
        repeat (3) tick();

        // Both ports reading continuously: grants alternate
        set1(1, 1, 0, 32, 4'h0, 32'h0);
        set2(1, 1, 0, 256, 4'h0, 32'h0);
        repeat (6) tick();
        idle();
        repeat (3) tick();

        // Read+write together: the write wins and no response is produced
        set2(1, 1, 1, 7, 4'hF, 32'h12345678); tick();
        set2(1, 1, 0, 7, 4'h0, 32'h0);        tick();
        idle();
        repeat (3) tick();

        // Out-of-range and last-word accesses
        set1(1, 0, 1, 12288, 4'hF, 32'hCAFEF00D); tick();
        set1(1, 1, 0, 12288, 4'h0, 32'h0);        tick();
        set2(1, 0, 1, 11053, 4'hF, 32'h55AA55AA); tick();
        set2(1, 1, 0, 11053, 4'h0, 32'h0);        tick();
        set1(1, 0, 1, 11052, 4'hF, 32'hA5A5F00F); tick();
        set1(1, 1, 0, 11052, 4'h0, 32'h0);        tick();
        idle();
        repeat (3) tick();

        // clken low for three cycles right after a read grant
        set1(1, 1, 0, 17, 4'h0, 32'h0);
        tick();
        idle();
        clken = 1'b0;
        set2(1, 1, 0, 32, 4'h0, 32'h0);
        repeat (3) tick();
        clken = 1'b1;
        tick();
        idle();
        repeat (4) tick();

        // Reset one cycle after an s2 read grant: no response, then a tie goes to s1
        set2(1, 1, 0, 256, 4'h0, 32'h0);
        tick();
        idle();
        reset_pulse();
        set1(1, 1, 0, 16, 4'h0, 32'h0);
        set2(1, 1, 0, 32, 4'h0, 32'h0);
        repeat (2) tick();
        idle();
        repeat (3) tick();

        // Reset after an s1 grant still restores s1 priority on the next tie
        set1(1, 1, 0, 0, 4'h0, 32'h0);
        tick();
        idle();
        reset_pulse();
        set1(1, 1, 0, 17, 4'h0, 32'h0);
        set2(1, 1, 0, 8191, 4'h0, 32'h0);
        repeat (3) tick();
        idle();
        repeat (3) tick();

        // Random traffic on both ports with occasional clken stalls
        repeat (400) begin
            a = ($urandom_range(0, 9) == 0) ? olist[$urandom_range(0, 2)] : alist[$urandom_range(0, 7)];
            set1($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 3) == 0), a,
                 4'($urandom), $urandom);
            a = ($urandom_range(0, 9) == 0) ? olist[$urandom_range(0, 2)] : alist[$urandom_range(0, 7)];
            set2($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom_range(0, 3) == 0), a,
                 4'($urandom), $urandom);
            clken = ($urandom_range(0, 9) != 0);
            tick();
        end
        clken = 1'b1;
        idle();
        repeat (6) tick();

        chk("q1_drained", 32'(q1.size()), 32'h0);
        chk("q2_drained", 32'(q2.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
